// File: rtl/riscv_pkg.sv
// Shared core definitions: PC width, the NOP encoding and the
// fetch bundle handed from the fetch stage to the IF/ID register.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction BRAM port, redirect input and the
// valid/ready handshake toward decode.
interface fetch_unit_if #(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int ADDR_BITS   = 14,
  parameter int QUEUE_DEPTH = 4
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                 imem_en;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [31:0]          imem_rdata;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 id_valid;
  logic                 id_ready;
  logic [31:0]          id_instruction;
  logic [XLEN-1:0]      id_pc;
  logic [CW-1:0]        queue_count;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instruction,
    output id_pc,
    output queue_count
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instruction,
    input  id_pc,
    input  queue_count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of fetched entries with wrap-around pointers and
// an explicit occupancy count; flush empties it in one edge.
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH):0]       count,
  output logic [WIDTH-1:0]             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, BRAM issue with queue
// credit, in-flight tracking and redirect flush.
module fetch_unit #(
  parameter int              XLEN        = riscv_pkg::XLEN,
  parameter int              ADDR_BITS   = 14,
  parameter int              QUEUE_DEPTH = 4,
  parameter int              MEM_LATENCY = 1,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.master bus
);

  import riscv_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int L  = MEM_LATENCY;
  localparam logic [CW:0] LIMIT = (CW+1)'(QUEUE_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [L-1:0]    infl_valid;
  logic [XLEN-1:0] infl_pc [L];
  logic [CW-1:0]   infl_cnt;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occ;
  logic            issue;
  logic            pop;
  logic            q_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < L; i++)
      infl_cnt = infl_cnt + CW'(infl_valid[i]);
  end

  // Reads already in flight hold a queue slot; a same-cycle pop is not credited.
  assign occ   = {1'b0, q_count} + {1'b0, infl_cnt};
  assign issue = !reset && !bus.redirect_valid && (occ < LIMIT);

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[ADDR_BITS+1:2];

  assign q_valid = (q_count != '0);
  assign pop     = q_valid && bus.id_ready && !bus.redirect_valid;

  assign push_entry = '{pc: infl_pc[L-1], instruction: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      infl_valid <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc   <= bus.redirect_pc & ~XLEN'(3);
      infl_valid <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      infl_valid[0] <= issue;
      for (int i = 1; i < L; i++)
        infl_valid[i] <= infl_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    infl_pc[0] <= fetch_pc;
    for (int i = 1; i < L; i++)
      infl_pc[i] <= infl_pc[i-1];
  end

  fetch_queue #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(QUEUE_DEPTH)
  ) queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (infl_valid[L-1]),
    .push_data (push_entry),
    .pop       (pop),
    .count     (q_count),
    .head      (head_entry)
  );

  assign bus.id_valid       = q_valid;
  assign bus.id_instruction = q_valid ? head_entry.instruction : NOP_INSTR;
  assign bus.id_pc          = q_valid ? head_entry.pc : '0;
  assign bus.queue_count    = q_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table on a latency-1 unit plus a
// stream scoreboard on latency-1 and latency-2 units.
module tb_fetch_unit;

  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        rdy   = 1'b0;
  logic        rv    = 1'b0;
  logic [63:0] rpc   = '0;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.XLEN(64), .ADDR_BITS(14), .QUEUE_DEPTH(4)) b1 ();
  fetch_unit_if #(.XLEN(64), .ADDR_BITS(14), .QUEUE_DEPTH(4)) b2 ();

  assign b1.id_ready       = rdy;
  assign b1.redirect_valid = rv;
  assign b1.redirect_pc    = rpc;
  assign b2.id_ready       = rdy;
  assign b2.redirect_valid = rv;
  assign b2.redirect_pc    = rpc;

  fetch_unit #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1.master));
  fetch_unit #(.MEM_LATENCY(2)) u2 (.clk(clk), .reset(reset), .bus(b2.master));

  // BRAM models: word i holds the value i
  logic [13:0] a1, a2, d2;
  always @(posedge clk) if (b1.imem_en) a1 <= b1.imem_addr;
  always @(posedge clk) begin
    if (b2.imem_en) a2 <= b2.imem_addr;
    d2 <= a2;
  end
  assign b1.imem_rdata = {18'd0, a1};
  assign b2.imem_rdata = {18'd0, d2};

  logic [63:0] exp_q [2][$];

  function automatic void reload(input logic [63:0] start);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      for (int i = 0; i < 256; i++)
        exp_q[k].push_back(start + 64'(4 * i));
    end
  endfunction

  task automatic step(input logic r, input logic y, input logic v,
                      input logic [63:0] p);
    @(posedge clk);
    #1;
    reset = r;
    rdy   = y;
    rv    = v;
    rpc   = p;
    if (r) reload(64'd0);
    else if (v) reload({p[63:2], 2'b00});
  endtask

  task automatic mon(input int k, input logic v, input logic [63:0] pc,
                     input logic [31:0] ins, input logic [2:0] cnt);
    logic [63:0] e;
    if (reset) return;
    checks++;
    if (!(cnt <= 3'd4)) begin
      errors++;
      $display("FAIL count_bound u%0d cnt=%0d max=4", k + 1, cnt);
    end
    if (!v) begin
      checks++;
      if (ins !== NOP_INSTR || pc !== 64'd0) begin
        errors++;
        $display("FAIL idle_out u%0d ins=%h pc=%h want %h/0", k + 1, ins, pc, NOP_INSTR);
      end
    end else if (rdy && !rv) begin
      checks++;
      if (exp_q[k].size() == 0) begin
        errors++;
        $display("FAIL stream_extra u%0d pc=%h", k + 1, pc);
      end else begin
        e = exp_q[k].pop_front();
        if (pc !== e || ins !== {18'd0, e[15:2]}) begin
          errors++;
          $display("FAIL stream u%0d pc=%h ins=%h want pc=%h ins=%h",
                   k + 1, pc, ins, e, {18'd0, e[15:2]});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b1.id_valid, b1.id_pc, b1.id_instruction, b1.queue_count);
    mon(1, b2.id_valid, b2.id_pc, b2.id_instruction, b2.queue_count);
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] epc;
    logic [2:0]  ecnt;
    logic        een;
    logic [13:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic y, input logic v,
                              input logic [63:0] p, input logic ev,
                              input logic [63:0] epc, input logic [2:0] ec,
                              input logic een, input logic [13:0] ea);
    vec_t t;
    t.rst = r; t.rdy = y; t.rv = v; t.rpc = p;
    t.ev = ev; t.epc = epc; t.ecnt = ec; t.een = een; t.eaddr = ea;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [31:0] ei;
    logic [63:0] ep;

    reload(64'd0);
    // reset release, id_ready high: first valid in cycle 2
    add(0,1,0,0,     0,0,0,1,0);
    add(0,1,0,0,     0,0,0,1,1);
    add(0,1,0,0,     1,0,1,1,2);
    add(0,1,0,0,     1,4,1,1,3);
    add(0,1,0,0,     1,8,1,1,4);
    // mid-stream reset, then id_ready low saturation
    add(1,0,0,0,     1,12,1,0,5);
    add(0,0,0,0,     0,0,0,1,0);
    add(0,0,0,0,     0,0,0,1,1);
    add(0,0,0,0,     1,0,1,1,2);
    add(0,0,0,0,     1,0,2,1,3);
    add(0,0,0,0,     1,0,3,0,4);
    add(0,0,0,0,     1,0,4,0,4);
    add(0,0,0,0,     1,0,4,0,4);
    add(0,1,0,0,     1,0,4,0,4);
    add(0,1,0,0,     1,4,3,1,4);
    add(0,1,0,0,     1,8,2,1,5);
    add(0,1,0,0,     1,12,2,1,6);
    add(0,1,0,0,     1,16,2,1,7);
    // redirect with 3 queued and 1 in flight
    add(1,0,0,0,     1,20,2,0,8);
    add(0,0,0,0,     0,0,0,1,0);
    add(0,0,0,0,     0,0,0,1,1);
    add(0,0,0,0,     1,0,1,1,2);
    add(0,0,0,0,     1,0,2,1,3);
    add(0,0,1,'h100, 1,0,3,0,4);
    add(0,1,0,0,     0,0,0,1,'h40);
    add(0,1,0,0,     0,0,0,1,'h41);
    add(0,1,0,0,     1,'h100,1,1,'h42);
    add(0,1,0,0,     1,'h104,1,1,'h43);
    // unaligned redirect with a simultaneous handshake
    add(0,1,1,'h203, 1,'h108,1,0,'h44);
    add(0,1,0,0,     0,0,0,1,'h80);
    add(0,1,0,0,     0,0,0,1,'h81);
    add(0,1,0,0,     1,'h200,1,1,'h82);
    add(0,1,0,0,     1,'h204,1,1,'h83);

    repeat (2) @(posedge clk);

    for (int t = 0; t < tbl.size(); t++) begin
      step(tbl[t].rst, tbl[t].rdy, tbl[t].rv, tbl[t].rpc);
      @(negedge clk);
      ep = tbl[t].ev ? tbl[t].epc : 64'd0;
      ei = tbl[t].ev ? {18'd0, tbl[t].epc[15:2]} : NOP_INSTR;
      checks++;
      if (b1.id_valid !== tbl[t].ev || b1.id_pc !== ep ||
          b1.id_instruction !== ei || b1.queue_count !== tbl[t].ecnt ||
          b1.imem_en !== tbl[t].een || b1.imem_addr !== tbl[t].eaddr) begin
        errors++;
        $display("FAIL row%0d got v=%b pc=%h ins=%h cnt=%0d en=%b addr=%h want v=%b pc=%h ins=%h cnt=%0d en=%b addr=%h",
                 t, b1.id_valid, b1.id_pc, b1.id_instruction, b1.queue_count,
                 b1.imem_en, b1.imem_addr, tbl[t].ev, ep, ei, tbl[t].ecnt,
                 tbl[t].een, tbl[t].eaddr);
      end
    end

    // randomised ready, occasional redirects and resets
    for (int n = 0; n < 1500; n++) begin
      logic y, v, r;
      y = ($urandom_range(0, 3) != 0) || (n % 200 < 20 ? 1'b0 : 1'b0);
      if (n % 200 >= 180) y = 1'b0;
      v = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(r, y, v, {$urandom, $urandom});
    end

    // one-cycle reset mid-stream on both units
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (b1.id_valid !== 1'b0 || b1.queue_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_u1 v=%b cnt=%0d want 0/0", b1.id_valid, b1.queue_count);
    end
    checks++;
    if (b2.id_valid !== 1'b0 || b2.queue_count !== 3'd0 || b2.imem_addr !== 14'd0) begin
      errors++;
      $display("FAIL reset_u2 v=%b cnt=%0d addr=%h want 0/0/0",
               b2.id_valid, b2.queue_count, b2.imem_addr);
    end
    repeat (12) step(0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (exp_q[1].size() > 256 - 8) begin
      errors++;
      $display("FAIL restart_u2 left=%0d want <=%0d", exp_q[1].size(), 256 - 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined RV64 core, replacing the bare program counter and instruction-memory hookup that feed the IF/ID register. It generates sequential PCs, issues reads to the synchronous instruction BRAM, and buffers returned instructions with their PCs in a small queue. It presents them to decode through a valid/ready handshake. Redirects from branch/jump resolution flush the queue and discard in-flight reads, so decode stalls and flushes never lose or duplicate an instruction.

## Interface
- XLEN, 64, PC width
- ADDR_BITS, 14, instruction-memory word-address width
- QUEUE_DEPTH, 4, instruction queue entries; power of 2, ≥2
- MEM_LATENCY, 1, instruction BRAM read latency in cycles; legal values 1 or 2
- RESET_PC, 0, PC fetched first after reset
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_en  out  1  read strobe to the instruction BRAM
- imem_addr  out  ADDR_BITS  word address, equal to fetch_pc[ADDR_BITS+1:2]
- imem_rdata  in  32  BRAM data, valid MEM_LATENCY cycles after the issue cycle
- redirect_valid  in  1  one-cycle pulse: pipeline redirect taken
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored and treated as 0
- id_valid  out  1  queue head holds a valid instruction
- id_ready  in  1  decode accepts the head this cycle
- id_instruction  out  32  head instruction; 32'h00000013 (NOP) when id_valid=0
- id_pc  out  XLEN  PC of the head instruction; 0 when id_valid=0
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries, for debug and perf

## Operation
- State:
  - fetch_pc: next PC to issue.
  - Queue of {pc, instruction}.
  - In-flight shift register of MEM_LATENCY {valid, pc} stages.
- Issue: imem_en=1 when no redirect this cycle and queue_count + inflight_count < QUEUE_DEPTH. inflight_count counts valid in-flight stages. A same-cycle pop is not credited.
- On issue, fetch_pc advances by 4 modulo 2^XLEN. The issued PC enters in-flight stage 0.
- Return: when the last in-flight stage is valid, {pc, imem_rdata} is written to the queue tail at that edge. The credit rule guarantees the queue never overflows.
- Pop: a handshake (id_valid && id_ready) removes the head at the edge. Push and pop in the same cycle leave queue_count unchanged.
- Redirect has priority over everything. At the edge it:
  - empties the queue;
  - clears every in-flight valid bit, so that data is discarded when it returns;
  - loads fetch_pc with {redirect_pc[XLEN-1:2], 2'b00}.
  No issue occurs in the redirect cycle, and a same-cycle pop is ignored.
- Reset:
  - fetch_pc = RESET_PC, queue empty, in-flight valids cleared.
  - imem_en=0, id_valid=0, id_instruction=NOP, id_pc=0, queue_count=0.
  - Reset mid-operation discards all queued and in-flight state identically.
- There is no instruction decoding. Misaligned or illegal instructions pass through unchanged.

## Timing
- Outputs id_* come from the queue head. They are registered and have no combinational path from imem_rdata or redirect_*.
- imem_en/imem_addr are combinational from state and redirect_valid only. They are independent of id_ready.
- Issue in cycle t, then queue write at the end of cycle t+MEM_LATENCY, then id_valid in cycle t+MEM_LATENCY+1.
- Out of reset with id_ready=1: issue in cycle 0, first id_valid in cycle MEM_LATENCY+1.
- Redirect pulse in cycle r: issue at redirect_pc in cycle r+1, and id_valid with that PC in cycle r+MEM_LATENCY+2.
- With id_ready held high, throughput is one instruction per cycle when QUEUE_DEPTH ≥ MEM_LATENCY+2. Otherwise the issue rate is reduced but results stay correct.
- With id_ready held low, issue stops once queue_count + inflight_count reaches QUEUE_DEPTH. The queue then fills to exactly QUEUE_DEPTH.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INSTR = 32'h00000013;
  - XLEN default;
  - a fetch_entry_t struct {pc, instruction} shared with the IF/ID register.
- Sub-module fetch_queue is the circular buffer. It has parameters WIDTH and DEPTH, push/pop/flush inputs and count/head outputs, and wrap-around read/write pointers with an explicit count.
- fetch_unit holds fetch_pc, the in-flight pipe, the credit logic and the redirect handling.

## Test plan
- Reset release, MEM_LATENCY=1, id_ready=1, BRAM word i = i: id_valid first in cycle 2, then PCs 0,4,8,... with instructions 0,1,2 on consecutive cycles, one per cycle.
- id_ready=0 from reset, QUEUE_DEPTH=4:
  - queue_count saturates at 4 and imem_en stays 0 after the 4th issue.
  - Raising id_ready delivers PCs 0,4,8,12,16 in order with no gap or duplicate.
- Redirect to 0x100 while the queue holds 3 entries and 1 read is in flight:
  - next cycle queue_count=0 and imem_addr=0x40;
  - the stale in-flight data is never presented;
  - first id_pc is 0x100.
- redirect_pc=0x203 with a simultaneous handshake: the pop is ignored, the queue is flushed, and the fetched PC is 0x200.
- MEM_LATENCY=2, QUEUE_DEPTH=4, randomised id_ready: the delivered PC sequence is strictly +4 and matches the BRAM contents; queue_count never exceeds 4.
- Reset asserted for one cycle mid-stream: id_valid=0 the next cycle, and the stream restarts from RESET_PC.
